// File: rtl/approx_err_pkg.sv
// Shared types and default widths for the approximate-adder error monitor.
// Derived widths assume the default W and CNT_W; modules recompute them from their own parameters.
package approx_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_W     = 8;
    localparam int DEF_CNT_W = 16;
    localparam int ABS_W     = DEF_W + 1;
    localparam int SERR_W    = DEF_W + 2;
    localparam int SAE_W     = DEF_W + 1 + DEF_CNT_W;
    localparam int BIAS_W    = DEF_W + 2 + DEF_CNT_W;

endpackage

// File: rtl/approx_err_if.sv
// Beat channel carrying the operands and the adder-under-test result into the monitor.
interface approx_err_if import approx_err_pkg::*; #(
    parameter int W = DEF_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W:0]   approx_sum;

    modport master (output in_valid, output in1, output in2, output approx_sum, input in_ready);
    modport slave  (input in_valid, input in1, input in2, input approx_sum, output in_ready);
endinterface

// File: rtl/approx_err_calc.sv
// Stage 1: registers the exact sum, signed error (approx - exact) and absolute error of an accepted beat.
module approx_err_calc import approx_err_pkg::*; #(
    parameter int W = DEF_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                accept,
    input  logic [W-1:0]        in1,
    input  logic [W-1:0]        in2,
    input  logic [W:0]          approx_sum,
    output logic [W:0]          exact,
    output logic signed [W+1:0] serr,
    output logic [W:0]          aerr,
    output logic                valid
);

    logic [W:0]          exact_s;
    logic signed [W+1:0] serr_s;
    logic signed [W+1:0] neg_s;
    logic [W:0]          aerr_s;

    // Combinational error arithmetic; magnitude always fits in W+1 bits.
    always_comb begin
        exact_s = {1'b0, in1} + {1'b0, in2};
        serr_s  = $signed({1'b0, approx_sum}) - $signed({1'b0, exact_s});
        neg_s   = -serr_s;
        if (serr_s[W+1]) begin
            aerr_s = neg_s[W:0];
        end else begin
            aerr_s = serr_s[W:0];
        end
    end

    // Capture register; data only moves on acceptance, valid marks a fresh beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exact <= '0;
            serr  <= '0;
            aerr  <= '0;
            valid <= 1'b0;
        end else if (accept) begin
            exact <= exact_s;
            serr  <= serr_s;
            aerr  <= aerr_s;
            valid <= 1'b1;
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/approx_err_monitor.sv
// Campaign controller and stage-2 statistics accumulator for an approximate adder.
// A campaign accepts num_samples beats, drains the pipeline, then pulses done.
module approx_err_monitor import approx_err_pkg::*; #(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [CNT_W-1:0]          num_samples,
    approx_err_if.slave               bus,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          err_count,
    output logic [W+CNT_W:0]          sae,
    output logic [W:0]                max_err,
    output logic signed [W+CNT_W+1:0] bias
);

    localparam int SAEW = W + 1 + CNT_W;
    localparam int BW   = W + 2 + CNT_W;

    state_t              state_r;
    logic [CNT_W-1:0]    target_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                in_ready_r;
    logic                busy_r;
    logic                done_r;
    logic [CNT_W-1:0]    err_count_r;
    logic [SAEW-1:0]     sae_r;
    logic [W:0]          max_err_r;
    logic signed [BW-1:0] bias_r;

    logic                accept_s;
    logic                clear_s;
    logic [W:0]          s1_exact;
    logic signed [W+1:0] s1_serr;
    logic [W:0]          s1_aerr;
    logic                s1_valid;
    logic                unused_exact;

    assign accept_s     = in_ready_r & bus.in_valid;
    assign clear_s      = (state_r == IDLE) & start;
    assign unused_exact = ^s1_exact;

    assign bus.in_ready = in_ready_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err_count    = err_count_r;
    assign sae          = sae_r;
    assign max_err      = max_err_r;
    assign bias         = bias_r;

    approx_err_calc #(.W(W)) u_calc (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept     (accept_s),
        .in1        (bus.in1),
        .in2        (bus.in2),
        .approx_sum (bus.approx_sum),
        .exact      (s1_exact),
        .serr       (s1_serr),
        .aerr       (s1_aerr),
        .valid      (s1_valid)
    );

    // Campaign FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            target_r   <= '0;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        target_r <= num_samples;
                        cnt_r    <= '0;
                        if (num_samples == '0) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r    <= RUN;
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r + CNT_W'(1) == target_r) begin
                            state_r    <= DRAIN;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Stage 1 empty means stage 2 has taken the final beat.
                    if (!s1_valid) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    // Stage 2 accumulators; cleared on an accepted start, otherwise held between campaigns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_r <= '0;
            sae_r       <= '0;
            max_err_r   <= '0;
            bias_r      <= '0;
        end else if (clear_s) begin
            err_count_r <= '0;
            sae_r       <= '0;
            max_err_r   <= '0;
            bias_r      <= '0;
        end else if (s1_valid) begin
            if (s1_aerr != '0) begin
                err_count_r <= err_count_r + CNT_W'(1);
            end else begin
                err_count_r <= err_count_r;
            end
            if (s1_aerr > max_err_r) begin
                max_err_r <= s1_aerr;
            end else begin
                max_err_r <= max_err_r;
            end
            sae_r  <= sae_r + SAEW'(s1_aerr);
            bias_r <= bias_r + BW'(s1_serr);
        end else begin
            err_count_r <= err_count_r;
            sae_r       <= sae_r;
            max_err_r   <= max_err_r;
            bias_r      <= bias_r;
        end
    end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor: hand-computed statistics, done latency, flow control and reset.
module tb_approx_err_monitor;
    import approx_err_pkg::*;

    localparam int W     = 8;
    localparam int CNT_W = 16;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      start = 1'b0;
    logic [CNT_W-1:0]          num_samples = '0;
    logic                      busy;
    logic                      done;
    logic [CNT_W-1:0]          err_count;
    logic [W+CNT_W:0]          sae;
    logic [W:0]                max_err;
    logic signed [W+CNT_W+1:0] bias;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    approx_err_if #(.W(W)) bus ();

    approx_err_monitor #(.W(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_samples (num_samples),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .err_count   (err_count),
        .sae         (sae),
        .max_err     (max_err),
        .bias        (bias)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_stats(input string tag, input longint ec, input longint sa,
                               input longint mx, input longint bi);
        check({tag, "_err_count"}, longint'(err_count), ec);
        check({tag, "_sae"}, longint'(sae), sa);
        check({tag, "_max_err"}, longint'(max_err), mx);
        check({tag, "_bias"}, longint'(bias), bi);
    endtask

    task automatic do_start(input int n);
        start       = 1'b1;
        num_samples = CNT_W'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offers one beat and returns 1 time unit after the edge that accepted it.
    task automatic send_beat(input int a, input int b, input int s);
        logic acc;
        acc            = 1'b0;
        bus.in1        = W'(a);
        bus.in2        = W'(b);
        bus.approx_sum = (W+1)'(s);
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in1        = '0;
        bus.in2        = '0;
        bus.approx_sum = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check_stats("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal campaign
        do_start(3);
        check("nom_busy", busy, 1);
        check("nom_in_ready", bus.in_ready, 1);
        send_beat(10, 20, 30);
        send_beat(5, 5, 12);
        send_beat(255, 255, 508);
        wait_done(lat);
        check("nom_done_lat", lat, 2);
        check("nom_busy_at_done", busy, 0);
        check_stats("nom", 2, 4, 2, 0);
        @(posedge clk);
        #1;
        check("nom_done_pulse", done, 0);
        check_stats("nom_hold", 2, 4, 2, 0);

        // Zero-length campaign: done right after start, stats cleared
        do_start(0);
        check("zero_done", done, 1);
        check("zero_in_ready", bus.in_ready, 0);
        check("zero_busy", busy, 0);
        check_stats("zero", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("zero_done_pulse", done, 0);
        check("zero_in_ready2", bus.in_ready, 0);

        // Extreme error
        do_start(1);
        send_beat(255, 255, 0);
        wait_done(lat);
        check("ext_done_lat", lat, 2);
        check_stats("ext", 1, 510, 510, -510);
        @(posedge clk);
        #1;

        // Restart clears stats, then flow-controlled 4-beat campaign
        do_start(4);
        check_stats("restart", 0, 0, 0, 0);
        check("restart_busy", busy, 1);
        send_beat(100, 50, 149);
        send_beat(0, 0, 3);
        start       = 1'b1;
        num_samples = CNT_W'(1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("flow_start_ignored_ready", bus.in_ready, 1);
        send_beat(200, 100, 300);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send_beat(7, 8, 20);
        bus.in1        = '0;
        bus.in2        = '0;
        bus.approx_sum = 9'd511;
        bus.in_valid   = 1'b1;
        check("flow_drain_ready", bus.in_ready, 0);
        wait_done(lat);
        check("flow_done_lat", lat, 2);
        check_stats("flow", 3, 9, 5, 7);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("flow_idle_ready", bus.in_ready, 0);
        check_stats("flow_hold", 3, 9, 5, 7);
        bus.in_valid = 1'b0;

        // Reset in the middle of a 5-beat campaign
        do_start(5);
        send_beat(1, 2, 10);
        send_beat(3, 3, 0);
        @(posedge clk);
        #1;
        check_stats("pre_rst", 2, 13, 7, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_done", done, 0);
        check_stats("mid_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.in1        = 8'd9;
        bus.in2        = 8'd9;
        bus.approx_sum = 9'd0;
        bus.in_valid   = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("post_rst_in_ready", bus.in_ready, 0);
        check("post_rst_busy", busy, 0);
        check_stats("post_rst", 0, 0, 0, 0);
        bus.in_valid = 1'b0;
        do_start(1);
        send_beat(1, 1, 3);
        wait_done(lat);
        check("post_rst_done_lat", lat, 2);
        check_stats("post_rst_run", 1, 1, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/approx_err_monitor.md
APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

Interface
REQ-001 SHALL have parameter W, default 8: operand width of the monitored adder.
REQ-002 SHALL have parameter CNT_W, default 16: sample-counter width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  begins a measurement campaign.
REQ-007 SHALL have port num_samples  in  CNT_W  campaign length, sampled on accepted start.
REQ-008 SHALL have port in_valid  in  1  operand/result beat valid.
REQ-009 SHALL have port in_ready  out  1  beat acceptance.
REQ-010 SHALL have ports in1 and in2, each  in  W  operands applied to the adder under test.
REQ-011 SHALL have port approx_sum  in  W+1  adder-under-test output.
REQ-012 SHALL have port busy  out  1  campaign in progress.
REQ-013 SHALL have port done  out  1  single-cycle completion pulse.
REQ-014 SHALL have port err_count  out  CNT_W  beats with nonzero error.
REQ-015 SHALL have port sae  out  W+1+CNT_W  sum of absolute errors.
REQ-016 SHALL have port max_err  out  W+1  maximum absolute error.
REQ-017 SHALL have port bias  out  W+2+CNT_W signed  sum of signed errors (approx minus exact).

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE: start=1 SHALL clear all statistics, latch num_samples, and move to RUN; if num_samples=0, it SHALL move to DONE instead.
REQ-020 RUN: in_ready SHALL be 1; a beat is accepted when in_valid&in_ready; after the num_samples-th accepted beat, the FSM SHALL move to DRAIN.
REQ-021 in_ready SHALL be 0 in IDLE, DRAIN, and DONE.
REQ-022 Stage 1 SHALL register the exact sum (in1+in2, W+1 bits), the signed error (W+2 bits), and the absolute error (W+1 bits) one cycle after acceptance.
REQ-023 Stage 2 SHALL update err_count, sae, max_err, and bias one cycle after stage 1; no accumulator can overflow at the stated widths.
REQ-024 DRAIN SHALL wait until stage 2 has absorbed the last beat, then move to DONE.
REQ-025 DONE SHALL assert done for exactly one cycle, then return to IDLE; done is asserted 3 cycles after the last accepted beat.
REQ-026 Statistics SHALL hold stable from done until the next accepted start.
REQ-027 busy SHALL be 1 in RUN and DRAIN and 0 otherwise.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 in_valid while in_ready=0 SHALL be ignored and SHALL have no side effects.
REQ-030 max_err SHALL update only when the new absolute error is strictly greater than the current value.

Reset
REQ-031 rst_n low SHALL immediately force IDLE and zero in_ready, busy, done, err_count, sae, max_err, bias, and pipeline valid bits, including mid-campaign.
REQ-032 Reset release SHALL require a fresh start before any beat is accepted.

Structure
REQ-033 Package approx_err_pkg SHALL hold the FSM state enum, the default W and CNT_W, and derived widths (ABS_W=W+1, SERR_W=W+2, SAE_W, BIAS_W).
REQ-034 Stage 1 SHALL be the sub-module approx_err_calc (operands + approx_sum in; registered exact, signed error, absolute error, and valid out).
REQ-035 The RTL SHALL be synthesizable with no latches.

Verification
REQ-036 Nominal campaign: num_samples=3; beats (10,20,30), (5,5,12), (255,255,508) -> err_count=2, sae=4, max_err=2, bias=0; done 3 cycles after the third beat.
REQ-037 Zero length: start with num_samples=0 -> done on the cycle after start; all stats 0; in_ready never 1.
REQ-038 Extreme error: num_samples=1; beat (255,255,0) -> max_err=510, sae=510, bias=-510, err_count=1.
REQ-039 Flow control: num_samples=4 with in_valid gaps of 0-3 cycles and start pulsed during RUN -> exactly 4 beats counted; start ignored; results match a software model.
REQ-040 Reset mid-run: rst_n low after 2 of 5 beats -> all outputs 0 and IDLE; a following 1-beat campaign (1,1,3) -> err_count=1, sae=1, bias=+1, with no residue from the aborted campaign.
REQ-041 Restart: after a completed campaign, a new start -> stats cleared to 0 on the following cycle.
